// File: rtl/image_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : image_pkg                                                 |
// | Purpose  : Shared state encoding and default image geometry for the  |
// |            image plotter and the upstream pixel counter.             |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
package image_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    RUN   = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  // Default geometry; the upstream counter is built with countLimit = c_LAST
  localparam int c_IMG_WIDTH  = 320;
  localparam int c_IMG_HEIGHT = 180;
  localparam int c_LAST       = c_IMG_WIDTH * c_IMG_HEIGHT - 1;
  localparam int c_X_OFFSET   = 0;
  localparam int c_Y_OFFSET   = 30;

endpackage
`default_nettype wire

// File: rtl/image_plotter_pipe_delay.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : pipe_delay                                                |
// | Purpose  : Fixed-depth register chain; carries {valid, x, y} so the  |
// |            coordinates line up with the image ROM read latency.      |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module pipe_delay #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clock,
  input  logic             resetN,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out
);

  logic [WIDTH-1:0] r_stage [DEPTH];

  // Shift the chain by one stage per clock; reset empties every stage
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      for (int i = 0; i < DEPTH; i++) r_stage[i] <= '0;
    end else begin
      r_stage[0] <= data_in;
      for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
    end
  end

  assign data_out = r_stage[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/image_plotter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : image_plotter                                             |
// | Purpose  : Walks the upstream pixel counter through one image, uses  |
// |            each index as the ROM address, tracks (col,row) without a |
// |            divider and drives the VGA adapter plot interface.        |
// | Options  : IMAGE_PLOTTER_TRANSPARENT_EN - suppress plot strobes for  |
// |            pixels whose colour equals TRANSPARENT_COLOUR.            |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module image_plotter
  import image_pkg::*;
#(
  parameter int IMG_WIDTH          = c_IMG_WIDTH,
  parameter int IMG_HEIGHT         = c_IMG_HEIGHT,
  parameter int ADDR_WIDTH         = 16,
  parameter int X_BITS             = 9,
  parameter int Y_BITS             = 8,
  parameter int COLOUR_BITS        = 3,
  parameter int ROM_LATENCY        = 2,
  parameter int X_OFFSET           = c_X_OFFSET,
  parameter int Y_OFFSET           = c_Y_OFFSET,
  parameter int TRANSPARENT_COLOUR = 0
) (
  input  logic                   clock,
  input  logic                   resetN,
  input  logic                   start,
  input  logic [ADDR_WIDTH-1:0]  count,
  output logic                   counter_enable,
  output logic                   counter_resetN,
  output logic [ADDR_WIDTH-1:0]  rom_address,
  input  logic [COLOUR_BITS-1:0] rom_data,
  output logic [X_BITS-1:0]      x,
  output logic [Y_BITS-1:0]      y,
  output logic [COLOUR_BITS-1:0] colour,
  output logic                   plot,
  output logic                   busy,
  output logic                   done
);

  localparam int LAST       = IMG_WIDTH * IMG_HEIGHT - 1;
  localparam int COL_BITS   = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  // row reaches IMG_HEIGHT after the final wrap, so leave room for it
  localparam int ROW_BITS   = $clog2(IMG_HEIGHT + 1);
  localparam int DRAIN_BITS = $clog2(ROM_LATENCY + 1);
  localparam int PIPE_W     = 1 + X_BITS + Y_BITS;

  localparam logic [ADDR_WIDTH-1:0] c_LAST_ADDR = ADDR_WIDTH'(LAST);
  localparam logic [COL_BITS-1:0]   c_COL_MAX   = COL_BITS'(IMG_WIDTH - 1);
  localparam logic [DRAIN_BITS-1:0] c_DRAIN_END = DRAIN_BITS'(ROM_LATENCY - 1);

  state_t                r_state;
  state_t                w_next_state;
  logic [COL_BITS-1:0]   r_col;
  logic [ROW_BITS-1:0]   r_row;
  logic [DRAIN_BITS-1:0] r_drain_cnt;
  logic                  w_issue_valid;
  logic [X_BITS-1:0]     w_issue_x;
  logic [Y_BITS-1:0]     w_issue_y;
  logic [PIPE_W-1:0]     w_pipe_out;
  logic                  w_valid_out;

  // State register
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) r_state <= IDLE;
    else         r_state <= w_next_state;
  end

  // Next-state logic; RUN ends on the cycle the saturating counter shows LAST
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (start) w_next_state = CLEAR;
      CLEAR:   w_next_state = RUN;
      RUN:     if (count == c_LAST_ADDR) w_next_state = DRAIN;
      DRAIN:   if (r_drain_cnt == c_DRAIN_END) w_next_state = DONE;
      DONE:    if (start) w_next_state = CLEAR;
      default: w_next_state = IDLE;
    endcase
  end

  // Column/row trackers replace index/IMG_WIDTH; drain counter flushes the pipe
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      r_col       <= '0;
      r_row       <= '0;
      r_drain_cnt <= '0;
    end else begin
      case (r_state)
        CLEAR: begin
          r_col       <= '0;
          r_row       <= '0;
          r_drain_cnt <= '0;
        end
        RUN: begin
          r_drain_cnt <= '0;
          if (r_col == c_COL_MAX) begin
            r_col <= '0;
            r_row <= r_row + 1'b1;
          end else begin
            r_col <= r_col + 1'b1;
          end
        end
        DRAIN:   r_drain_cnt <= r_drain_cnt + 1'b1;
        default: ;
      endcase
    end
  end

  // Per-state outputs to the counter, ROM and status flags
  always_comb begin
    counter_enable = 1'b0;
    counter_resetN = 1'b1;
    rom_address    = '0;
    busy           = 1'b0;
    done           = 1'b0;
    w_issue_valid  = 1'b0;
    case (r_state)
      CLEAR: begin
        counter_resetN = 1'b0;
        busy           = 1'b1;
      end
      RUN: begin
        counter_enable = 1'b1;
        rom_address    = count;
        busy           = 1'b1;
        w_issue_valid  = 1'b1;
      end
      DRAIN:   busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // Offsets are added at issue time; results wrap to the coordinate widths
  assign w_issue_x = X_BITS'(X_OFFSET) + X_BITS'(r_col);
  assign w_issue_y = Y_BITS'(Y_OFFSET) + Y_BITS'(r_row);

  pipe_delay #(
    .WIDTH (PIPE_W),
    .DEPTH (ROM_LATENCY)
  ) u_pipe_delay (
    .clock    (clock),
    .resetN   (resetN),
    .data_in  ({w_issue_valid, w_issue_x, w_issue_y}),
    .data_out (w_pipe_out)
  );

  assign w_valid_out = w_pipe_out[PIPE_W-1];
  assign x           = w_pipe_out[PIPE_W-2 -: X_BITS];
  assign y           = w_pipe_out[Y_BITS-1:0];
  // Colour is meaningful only beside a valid pixel; keep it quiet otherwise
  assign colour      = w_valid_out ? rom_data : '0;

`ifdef IMAGE_PLOTTER_TRANSPARENT_EN
  assign plot = w_valid_out && (rom_data != COLOUR_BITS'(TRANSPARENT_COLOUR));
`else
  assign plot = w_valid_out;
`endif

endmodule
`default_nettype wire

// File: tb/tb_image_plotter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_image_plotter                                          |
// | Purpose  : Directed self-checking bench for image_plotter with a     |
// |            saturating counter model and a 2-cycle image ROM model.   |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module tb_image_plotter;

  localparam int W    = 320;
  localparam int H    = 180;
  localparam int LAST = W * H - 1;
  localparam int NPIX = W * H;

  logic        clock;
  logic        resetN;
  logic        start;
  logic [15:0] count;
  logic        counter_enable;
  logic        counter_resetN;
  logic [15:0] rom_address;
  logic [2:0]  rom_data;
  logic [8:0]  x;
  logic [7:0]  y;
  logic [2:0]  colour;
  logic        plot;
  logic        busy;
  logic        done;
  logic [2:0]  r_rom1;

  int total;
  int bad;

  image_plotter dut (
    .clock          (clock),
    .resetN         (resetN),
    .start          (start),
    .count          (count),
    .counter_enable (counter_enable),
    .counter_resetN (counter_resetN),
    .rom_address    (rom_address),
    .rom_data       (rom_data),
    .x              (x),
    .y              (y),
    .colour         (colour),
    .plot           (plot),
    .busy           (busy),
    .done           (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Image ROM contents
  function automatic logic [2:0] rom_fn(input int a);
`ifdef IMAGE_PLOTTER_TRANSPARENT_EN
    return (a == 5) ? 3'b101 : 3'b000;
`else
    return 3'(a % 8);
`endif
  endfunction

  // Whether pixel p is expected to strobe plot
  function automatic logic plot_fn(input int p);
`ifdef IMAGE_PLOTTER_TRANSPARENT_EN
    return rom_fn(p) != 3'b000;
`else
    return (p >= 0);
`endif
  endfunction

  // Upstream counter model: sync clear, saturates at LAST
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN)                                count <= '0;
    else if (!counter_resetN)                   count <= '0;
    else if (counter_enable && count != 16'(LAST)) count <= count + 16'd1;
  end

  // Two-cycle image ROM model
  always_ff @(posedge clock) begin
    r_rom1   <= rom_fn(int'(rom_address));
    rom_data <= r_rom1;
  end

  task automatic test_reset();
    resetN = 1'b0;
    start  = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    total++; if (plot !== 1'b0)            begin bad++; $display("FAIL reset_plot got=%b want=0", plot); end
    total++; if (x !== 9'd0 || y !== 8'd0) begin bad++; $display("FAIL reset_xy got=(%0d,%0d) want=(0,0)", x, y); end
    total++; if (colour !== 3'd0)          begin bad++; $display("FAIL reset_colour got=%0d want=0", colour); end
    total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL reset_flags got busy=%b done=%b want 0,0", busy, done); end
    total++; if (counter_enable !== 1'b0 || counter_resetN !== 1'b1) begin bad++; $display("FAIL reset_counter got en=%b rstN=%b want 0,1", counter_enable, counter_resetN); end
    total++; if (rom_address !== 16'd0)    begin bad++; $display("FAIL reset_addr got=%0d want=0", rom_address); end
    resetN = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    total++; if (busy !== 1'b0 || plot !== 1'b0) begin bad++; $display("FAIL idle_hold got busy=%b plot=%b want 0,0", busy, plot); end
  endtask

  // Full draw with start held high through the first RUN cycles
  task automatic test_full_draw();
    int  plots;
    int  p;
    logic exp_valid;
    logic exp_plot;
    plots = 0;
    start = 1'b1;
    @(posedge clock); #1;
    total++; if (counter_resetN !== 1'b0 || counter_enable !== 1'b0 || busy !== 1'b1)
      begin bad++; $display("FAIL clear_state got rstN=%b en=%b busy=%b want 0,0,1", counter_resetN, counter_enable, busy); end
    @(posedge clock); #1;
    total++; if (counter_resetN !== 1'b1) begin bad++; $display("FAIL clear_one_cycle got rstN=%b want 1", counter_resetN); end
    for (int k = 0; k <= NPIX + 2; k++) begin
      if (k == 10) start = 1'b0;
      p         = k - 2;
      exp_valid = (k >= 2) && (k <= NPIX + 1);
      exp_plot  = exp_valid && plot_fn(p);
      total++; if (plot !== exp_plot) begin bad++; $display("FAIL draw_plot k=%0d got=%b want=%b", k, plot, exp_plot); end
      if (plot === 1'b1) plots++;
      if (exp_valid) begin
        total++;
        if (x !== 9'(p % W) || y !== 8'(30 + p / W) || colour !== rom_fn(p)) begin
          bad++; $display("FAIL draw_pixel p=%0d got=(%0d,%0d,c%0d) want=(%0d,%0d,c%0d)",
                          p, x, y, colour, p % W, 30 + p / W, rom_fn(p));
        end
      end
      if (k < NPIX) begin
        total++; if (counter_enable !== 1'b1 || rom_address !== 16'(k))
          begin bad++; $display("FAIL draw_issue k=%0d got en=%b addr=%0d want 1,%0d", k, counter_enable, rom_address, k); end
      end
      if (p == 319) begin
        total++; if (x !== 9'd319 || y !== 8'd30) begin bad++; $display("FAIL row_end got=(%0d,%0d) want=(319,30)", x, y); end
      end
      if (p == 320) begin
        total++; if (x !== 9'd0 || y !== 8'd31) begin bad++; $display("FAIL row_wrap got=(%0d,%0d) want=(0,31)", x, y); end
      end
      if (p == LAST) begin
        total++; if (x !== 9'd319 || y !== 8'd209) begin bad++; $display("FAIL last_pixel got=(%0d,%0d) want=(319,209)", x, y); end
      end
      if (k == NPIX) begin
        total++; if (counter_enable !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL drain_entry got en=%b busy=%b want 0,1", counter_enable, busy); end
      end
      if (k == NPIX + 2) begin
        total++; if (done !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL done_level got done=%b busy=%b want 1,0", done, busy); end
      end else begin
        @(posedge clock); #1;
      end
    end
    @(posedge clock); #1;
    total++; if (done !== 1'b1 || plot !== 1'b0) begin bad++; $display("FAIL done_hold got done=%b plot=%b want 1,0", done, plot); end
`ifdef IMAGE_PLOTTER_TRANSPARENT_EN
    total++; if (plots !== 1) begin bad++; $display("FAIL plot_count got=%0d want=1", plots); end
`else
    total++; if (plots !== NPIX) begin bad++; $display("FAIL plot_count got=%0d want=%0d", plots, NPIX); end
`endif
  endtask

  // Redraw from DONE, then abort with reset at index 1000
  task automatic test_redraw_abort();
    int   p;
    logic exp_plot;
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    total++; if (counter_resetN !== 1'b0 || done !== 1'b0 || busy !== 1'b1)
      begin bad++; $display("FAIL redraw_clear got rstN=%b done=%b busy=%b want 0,0,1", counter_resetN, done, busy); end
    @(posedge clock); #1;
    for (int k = 0; k <= 1000; k++) begin
      p        = k - 2;
      exp_plot = (k >= 2) && plot_fn(p);
      total++; if (plot !== exp_plot || rom_address !== 16'(k))
        begin bad++; $display("FAIL redraw_run k=%0d got plot=%b addr=%0d want %b,%0d", k, plot, rom_address, exp_plot, k); end
      if (k < 1000) begin
        @(posedge clock); #1;
      end
    end
    resetN = 1'b0;
    #1;
    total++; if (plot !== 1'b0 || busy !== 1'b0 || counter_enable !== 1'b0)
      begin bad++; $display("FAIL abort_immediate got plot=%b busy=%b en=%b want 0,0,0", plot, busy, counter_enable); end
    total++; if (x !== 9'd0 || y !== 8'd0 || rom_address !== 16'd0 || counter_resetN !== 1'b1)
      begin bad++; $display("FAIL abort_outputs got x=%0d y=%0d addr=%0d rstN=%b want 0,0,0,1", x, y, rom_address, counter_resetN); end
    @(negedge clock);
    resetN = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(posedge clock); #1;
      total++; if (plot !== 1'b0 || busy !== 1'b0 || done !== 1'b0)
        begin bad++; $display("FAIL abort_idle k=%0d got plot=%b busy=%b done=%b want 0,0,0", k, plot, busy, done); end
    end
  endtask

  initial begin
    total  = 0;
    bad    = 0;
    resetN = 1'b0;
    start  = 1'b0;
    test_reset();
    test_full_draw();
    test_redraw_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
